// File: rtl/ram_ps2.sv
// Simple dual-port RAM with a built-in default image that is present from power-up
// and can be restored by a reset-triggered init sequence (one word per clock).
module ram_ps2 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] wraddress,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] rdaddress,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  init_busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Low address nibble repeated across the word, truncated at DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] image_word(input int unsigned idx);
    logic [3:0]              nib;
    logic [4*DATA_WIDTH-1:0] rep;
    nib = idx[3:0];
    rep = {DATA_WIDTH{nib}};
    return rep[DATA_WIDTH-1:0];
  endfunction

  logic [ADDR_WIDTH-1:0] cnt_q = '0;
  logic [ADDR_WIDTH-1:0] cnt_d;
  logic                  busy_q = 1'b0;
  logic                  busy_d;
  logic [DATA_WIDTH-1:0] q_q = '0;
  logic [DATA_WIDTH-1:0] q_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rd [DEPTH];

  always_comb begin
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    q_d       = q_q;
    mem_we    = 1'b0;
    mem_waddr = wraddress;
    mem_wdata = data;
    if (busy_q) begin
      // Init owns the write port; user writes are dropped and q reads as zero.
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = image_word(int'(cnt_q));
      cnt_d     = cnt_q + 1'b1;
      q_d       = '0;
      if (&cnt_q) begin
        busy_d = 1'b0;
      end
    end else begin
      mem_we = wren;
      q_d    = mem_rd[rdaddress];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q    <= '0;
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      q_q    <= q_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // One register per word so each can carry its own power-up value.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [DATA_WIDTH-1:0] word_q = image_word(i);

    always_ff @(posedge clock) begin
      if (!reset && mem_we && (mem_waddr == ADDR_WIDTH'(i))) begin
        word_q <= mem_wdata;
      end
    end

    assign mem_rd[i] = word_q;
  end

  assign q         = q_q;
  assign init_busy = busy_q;

endmodule

// File: tb/tb_ram_ps2.sv
// Directed and randomized checks of ram_ps2 against an array model of the memory.
module tb_ram_ps2;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] data;
  logic [AW-1:0] wraddress;
  logic          wren;
  logic [AW-1:0] rdaddress;
  logic [DW-1:0] q;
  logic          init_busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] model [DEPTH];

  ram_ps2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .data      (data),
    .wraddress (wraddress),
    .wren      (wren),
    .rdaddress (rdaddress),
    .q         (q),
    .init_busy (init_busy)
  );

  always #5 clock = ~clock;

  // Default contents: word i is (i mod 16) * 0x11.
  function automatic logic [DW-1:0] default_word(input int i);
    return DW'((i % 16) * 17);
  endfunction

  task automatic model_default();
    for (int i = 0; i < DEPTH; i++) model[i] = default_word(i);
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    logic [DW-1:0] exp_q;

    reset     = 1'b0;
    wren      = 1'b0;
    data      = '0;
    wraddress = '0;
    rdaddress = '0;
    model_default();

    // Power-up image without any reset.
    repeat (5) cycle();
    check("powerup_busy", 32'(init_busy), 32'd0);
    rdaddress = 4'd1;
    cycle();
    check("powerup_rd1", 32'(q), 32'h11);
    rdaddress = 4'd2;
    cycle();
    check("powerup_rd2", 32'(q), 32'h22);

    // Plain write then read back; neighbour untouched.
    wren = 1'b1; wraddress = 4'd3; data = 8'hA5;
    cycle();
    model[3] = 8'hA5;
    wren = 1'b0; rdaddress = 4'd3;
    cycle();
    check("wr_rd3", 32'(q), 32'hA5);
    rdaddress = 4'd4;
    cycle();
    check("rd4_untouched", 32'(q), 32'h44);

    // Read-during-write to the same address returns old data.
    wren = 1'b1; wraddress = 4'd5; rdaddress = 4'd5; data = 8'h3C;
    cycle();
    check("rdw_old", 32'(q), 32'h55);
    model[5] = 8'h3C;
    wren = 1'b0;
    cycle();
    check("rdw_new", 32'(q), 32'h3C);

    // Random traffic against the model.
    for (int k = 0; k < 200; k++) begin
      wren      = 1'($urandom_range(0, 1));
      wraddress = AW'($urandom_range(0, DEPTH - 1));
      rdaddress = AW'($urandom_range(0, DEPTH - 1));
      data      = DW'($urandom);
      exp_q     = model[rdaddress];
      cycle();
      if (wren) model[wraddress] = data;
      check("rand_q", 32'(q), 32'(exp_q));
    end
    wren = 1'b0;

    // Reset restores the image; writes during init are dropped.
    wren = 1'b1; wraddress = 4'd0; data = 8'hFF;
    cycle();
    wren = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    model_default();
    check("rst_q", 32'(q), 32'd0);
    check("rst_busy", 32'(init_busy), 32'd1);
    wren = 1'b1; wraddress = 4'd8; data = 8'h77; rdaddress = 4'd6;
    for (int k = 1; k < DEPTH; k++) begin
      cycle();
      check("init_busy_hi", 32'(init_busy), 32'd1);
      check("init_q_zero", 32'(q), 32'd0);
    end
    wren = 1'b0;
    cycle();
    check("init_done", 32'(init_busy), 32'd0);

    // First normal access right after init completes.
    wren = 1'b1; wraddress = 4'd9; data = 8'h5A; rdaddress = 4'd0;
    cycle();
    model[9] = 8'h5A;
    check("post_init_rd0", 32'(q), 32'h00);
    wren = 1'b0; rdaddress = 4'd8;
    cycle();
    check("dropped_wr8", 32'(q), 32'h88);
    rdaddress = 4'd9;
    cycle();
    check("post_init_wr9", 32'(q), 32'h5A);

    // Reset again mid-init (counter at 8) restarts the whole sequence.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (8) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    model_default();
    n = 0;
    while (init_busy === 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    check("reinit_len", 32'(n), 32'd16);
    for (int a = 0; a < DEPTH; a++) begin
      rdaddress = AW'(a);
      cycle();
      check("final_image", 32'(q), 32'(model[a]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
